// File: rtl/dfdd_stream_pkg.sv
// dfdd_stream_pkg: shared types for the depth stream packer
package dfdd_stream_pkg;
  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [15:0] c;
    logic [15:0] z;
  } depth_entry_t;
  localparam int ENTRY_WIDTH = 34;
  typedef enum logic {SEEK, LOCK} seq_state_t;
endpackage

// File: rtl/depth_stream_fifo.sv
// depth_stream_fifo: first-word-fall-through sync FIFO with a registered output word
module depth_stream_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, nidx;
  logic [AW:0] cnt;
  logic vld, do_push, do_pop, avail;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = !vld;
  assign level = cnt;
  assign do_push = push && !full;
  assign do_pop = pop && vld;
  // The output word stays counted in cnt until its handshake, so the head index is rptr itself
  assign nidx = do_pop ? rptr + 1'b1 : rptr;
  assign avail = do_pop ? cnt > (AW+1)'(1) : cnt != '0;
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      vld <= 1'b0;
      dout <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (!vld || do_pop) begin
        vld <= avail;
        if (avail) dout <= mem[nidx];
      end
    end
endmodule

// File: rtl/depth_stream_packer_fp16.sv
// depth_stream_packer_fp16: buffers depth pixels into a 32-bit ready/valid stream with raster checking
module depth_stream_packer_fp16
  import dfdd_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 64,
  parameter int FP_WIDTH_REG = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [FP_WIDTH_REG-1:0]      z_i,
  input  logic [FP_WIDTH_REG-1:0]      c_i,
  input  logic [15:0]                  col_i,
  input  logic [15:0]                  row_i,
  input  logic                         valid_i,
  output logic [31:0]                  m_tdata_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic                         m_tuser_o,
  output logic                         m_tlast_o,
  output logic                         overflow_o,
  output logic                         seq_error_o,
  input  logic                         clear_i,
  output logic [15:0]                  frame_count_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
  depth_entry_t din, dout;
  seq_state_t state;
  logic [15:0] exp_col, exp_row;
  logic full, empty, origin, hit, frame_end;
  assign origin = col_i == '0 && row_i == '0;
  assign hit = col_i == exp_col && row_i == exp_row;
  assign frame_end = col_i == LAST_COL && row_i == LAST_ROW;
  assign din = '{tuser: origin, tlast: col_i == LAST_COL, c: c_i, z: z_i};
  assign m_tdata_o = {dout.c, dout.z};
  assign m_tuser_o = dout.tuser;
  assign m_tlast_o = dout.tlast;
  assign m_tvalid_o = !empty;
  depth_stream_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (valid_i),
    .din   (din),
    .full  (full),
    .pop   (m_tready_i),
    .dout  (dout),
    .empty (empty),
    .level (fifo_level_o)
  );
  // The checker sees every valid pixel, including those the full FIFO drops
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= SEEK;
      exp_col <= '0;
      exp_row <= '0;
      frame_count_o <= '0;
      overflow_o <= 1'b0;
      seq_error_o <= 1'b0;
    end else begin
      overflow_o <= (valid_i && full) || (overflow_o && !clear_i);
      seq_error_o <= (valid_i && state == LOCK && !hit) || (seq_error_o && !clear_i);
      if (valid_i) begin
        if (state == SEEK || !hit) begin
          state <= origin ? LOCK : SEEK;
          exp_col <= 16'd1;
          exp_row <= '0;
        end else if (frame_end) begin
          state <= SEEK;
          frame_count_o <= frame_count_o + 16'd1;
        end else begin
          exp_col <= exp_col == LAST_COL ? '0 : exp_col + 16'd1;
          exp_row <= exp_col == LAST_COL ? exp_row + 16'd1 : exp_row;
        end
      end
    end
endmodule

// File: tb/tb_depth_stream_packer_fp16.sv
// tb_depth_stream_packer_fp16: scoreboard bench for the depth stream packer (4x2 image, 4-entry FIFO)
module tb_depth_stream_packer_fp16;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int FD = 4;
  logic clk = 0, rst_i = 1, valid_i = 0, m_tready_i = 0, clear_i = 0;
  logic [15:0] z_i = 0, c_i = 0, col_i = 0, row_i = 0;
  logic [31:0] m_tdata_o;
  logic m_tvalid_o, m_tuser_o, m_tlast_o, overflow_o, seq_error_o;
  logic [15:0] frame_count_o;
  logic [2:0] fifo_level_o;
  int n_cmp = 0, n_bad = 0, mlvl = 0;
  logic [33:0] sb[$];
  logic stall = 0;
  logic [34:0] held;
  depth_stream_packer_fp16 #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .FIFO_DEPTH(FD), .FP_WIDTH_REG(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i), .valid_i(valid_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tuser_o(m_tuser_o),
    .m_tlast_o(m_tlast_o), .overflow_o(overflow_o), .seq_error_o(seq_error_o), .clear_i(clear_i),
    .frame_count_o(frame_count_o), .fifo_level_o(fifo_level_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Occupancy model decides which driven pixels are kept; words are checked on each handshake
  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      mlvl = 0;
      stall = 0;
    end else begin
      logic pop, psh;
      logic [33:0] e;
      if (stall) chk("stall_hold", {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}, held);
      pop = m_tvalid_o && m_tready_i;
      if (pop) begin
        if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("word", {m_tuser_o, m_tlast_o, m_tdata_o}, e);
        end
      end
      stall = m_tvalid_o && !m_tready_i;
      held = {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o};
      psh = valid_i && mlvl < FD;
      if (psh) sb.push_back({col_i == 0 && row_i == 0, col_i == IW - 1, c_i, z_i});
      mlvl = mlvl + int'(psh) - int'(pop);
    end
  end
  task automatic send(input int k, input logic [15:0] zz, input logic [15:0] cc);
    valid_i = 1;
    col_i = 16'(k % IW);
    row_i = 16'((k / IW) % IH);
    z_i = zz;
    c_i = cc;
    @(posedge clk); #1;
    valid_i = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic frame();
    for (int k = 0; k < IW * IH; k++) send(k, 16'h3C00 + 16'(k), 16'(k));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    chk("rst_tvalid", m_tvalid_o, 0);
    chk("rst_tdata", m_tdata_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_flags", {overflow_o, seq_error_o, m_tuser_o, m_tlast_o}, 0);
    chk("rst_count", frame_count_o, 0);
    // 1: clean frame, latency of one cycle after the first write
    m_tready_i = 1;
    for (int k = 0; k < IW * IH; k++) begin
      send(k, 16'h3C00 + 16'(k), 16'(k));
      if (k == 0) chk("lat_before", m_tvalid_o, 0);
      if (k == 1) chk("lat_after", m_tvalid_o, 1);
    end
    idle(6);
    chk("t1_count", frame_count_o, 1);
    chk("t1_flags", {overflow_o, seq_error_o}, 0);
    chk("t1_drained", sb.size(), 0);
    // 2: stalled output saturates the FIFO, extra pixels dropped
    m_tready_i = 0;
    for (int k = 0; k < 6; k++) send(k, 16'h4000 + 16'(k), 16'h00A0 + 16'(k));
    chk("t2_level", fifo_level_o, 4);
    chk("t2_overflow", overflow_o, 1);
    chk("t2_held", sb.size(), 4);
    m_tready_i = 1;
    idle(7);
    chk("t2_drained", sb.size(), 0);
    chk("t2_level0", fifo_level_o, 0);
    clear_i = 1;
    idle(1);
    clear_i = 0;
    chk("t2_clear", overflow_o, 0);
    // 3: random backpressure with sparse input, arbitrary payload bits
    for (int k = 6; k < 24; k++) begin
      m_tready_i = 1'($urandom_range(0, 1));
      send(k, (k % 5 == 0) ? 16'h7E01 : 16'($urandom), (k % 7 == 0) ? 16'hFC00 : 16'($urandom));
      repeat (2) begin m_tready_i = 1'($urandom_range(0, 1)); idle(1); end
    end
    m_tready_i = 1;
    idle(8);
    chk("t3_drained", sb.size(), 0);
    chk("t3_count", frame_count_o, 4);
    chk("t3_flags", {overflow_o, seq_error_o}, 0);
    // 4: skip pixel (2,0) -> error, frame abandoned
    for (int k = 0; k < IW * IH; k++) if (k != 2) begin
      send(k, 16'h5000 + 16'(k), 16'(k));
      if (k == 1) chk("t4_no_err_yet", seq_error_o, 0);
      if (k == 3) chk("t4_seq_err", seq_error_o, 1);
    end
    idle(2);
    chk("t4_count_same", frame_count_o, 4);
    frame();
    idle(6);
    chk("t4_count_next", frame_count_o, 5);
    chk("t4_err_sticky", seq_error_o, 1);
    clear_i = 1;
    idle(1);
    clear_i = 0;
    chk("t4_clear", seq_error_o, 0);
    chk("t4_drained", sb.size(), 0);
    // 5: asynchronous reset mid-frame with three words buffered
    m_tready_i = 0;
    for (int k = 0; k < 3; k++) send(k, 16'h6000 + 16'(k), 16'(k));
    chk("t5_level3", fifo_level_o, 3);
    chk("t5_tvalid_pre", m_tvalid_o, 1);
    #2 rst_i = 1;
    #1;
    chk("t5_rst_tvalid", m_tvalid_o, 0);
    chk("t5_rst_level", fifo_level_o, 0);
    chk("t5_rst_count", frame_count_o, 0);
    chk("t5_rst_tdata", m_tdata_o, 0);
    @(posedge clk); #3 rst_i = 0;
    @(posedge clk); #1;
    m_tready_i = 1;
    frame();
    idle(6);
    chk("t5_count", frame_count_o, 1);
    chk("t5_drained", sb.size(), 0);
    // 6: clear in the same cycle as a drop; set wins
    m_tready_i = 0;
    for (int k = 0; k < 4; k++) send(k, 16'h7000 + 16'(k), 16'(k));
    chk("t6_full", fifo_level_o, 4);
    clear_i = 1;
    send(4, 16'h7004, 16'h0004);
    clear_i = 0;
    chk("t6_set_wins", overflow_o, 1);
    m_tready_i = 1;
    idle(3);
    for (int k = 5; k < 8; k++) send(k, 16'h7000 + 16'(k), 16'(k));
    idle(6);
    chk("t6_count", frame_count_o, 2);
    chk("t6_drained", sb.size(), 0);
    chk("t6_overflow_held", overflow_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
